memory_read_arbiter_tagged: RTL and testbench



---
 rtl/memory_read_arbiter_tagged.sv | 137 +++++++++++++
 tb/tb_memory_read_arbiter_tagged.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_read_arbiter_tagged.sv
// N-way memory read arbiter (round-robin or priority + starvation guard) with a fixed-latency
// tag pipeline that steers each read response back to the requester that was granted.
module memory_read_arbiter_tagged #(
   parameter int N                 = 5,
   parameter int MEMORY_ADDR_WIDTH = 11,
   parameter int MEMORY_WIDTH      = 20,
   parameter int READ_LATENCY      = 1,
   parameter int ARB_MODE          = 0,
   parameter int STARVE_LIMIT      = 15
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [N-1:0]                        req_valid,
   input  logic [N*MEMORY_ADDR_WIDTH-1:0]      req_addr,
   output logic [N-1:0]                        req_ready,
   output logic [N-1:0]                        rsp_valid,
   output logic [MEMORY_WIDTH-1:0]             rsp_data,
   output logic                                mem_valid,
   output logic [MEMORY_ADDR_WIDTH-1:0]        mem_addr,
   input  logic                                mem_ready,
   input  logic [MEMORY_WIDTH-1:0]             mem_data,
   output logic [$clog2(READ_LATENCY+1)-1:0]   outstanding
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam int OW = $clog2(READ_LATENCY + 1);
   localparam int AW = MEMORY_ADDR_WIDTH;
   localparam int P  = N - 1;

   logic [IW-1:0]                      rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]                      wait_q [P];
   logic [CW-1:0]                      wait_d [P];
   logic [READ_LATENCY-1:0]            v_q;
   logic [READ_LATENCY-1:0][IW-1:0]    idx_q;
   logic [OW-1:0]                      outstanding_q, outstanding_d;

   logic [N-1:0]  grant;
   logic [N-1:0]  starved;
   logic [N-1:0]  nonpri;
   logic [IW-1:0] win_idx;
   logic          accept;

   function automatic logic [N-1:0] rr_pick(input logic [N-1:0] cand, input logic [IW-1:0] ptr);
      logic [N-1:0]  pick;
      logic [IW-1:0] idx;
      logic          found;
      pick  = '0;
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
         idx = IW'((int'(ptr) + k) % N);
         if (!found && cand[idx]) begin
            pick[idx] = 1'b1;
            found     = 1'b1;
         end
      end
      return pick;
   endfunction

   // A starved port only counts while it is still requesting this cycle.
   always_comb begin
      starved = '0;
      nonpri  = req_valid;
      nonpri[P] = 1'b0;
      for (int i = 0; i < P; i++) begin
         starved[i] = (STARVE_LIMIT != 0) && req_valid[i] && (wait_q[i] == CW'(STARVE_LIMIT));
      end
      grant = '0;
      if (ARB_MODE == 0) begin
         grant = rr_pick(req_valid, rr_ptr_q);
      end else if (|starved) begin
         grant = rr_pick(starved, rr_ptr_q);
      end else if (req_valid[P]) begin
         grant[P] = 1'b1;
      end else begin
         grant = rr_pick(nonpri, rr_ptr_q);
      end
   end

   always_comb begin
      win_idx  = '0;
      mem_addr = '0;
      for (int i = 0; i < N; i++) begin
         if (grant[i]) begin
            win_idx  = IW'(i);
            mem_addr = req_addr[i*AW +: AW];
         end
      end
   end

   assign mem_valid = |req_valid;
   assign accept    = mem_valid & mem_ready;
   assign req_ready = grant & {N{mem_ready}};

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (accept && (ARB_MODE == 0 || win_idx != IW'(P))) begin
         rr_ptr_d = IW'((int'(win_idx) + 1) % N);
         if (ARB_MODE != 0 && rr_ptr_d == IW'(P)) rr_ptr_d = '0;
      end
      for (int i = 0; i < P; i++) begin
         if (!req_valid[i] || (accept && grant[i])) wait_d[i] = '0;
         else if (wait_q[i] != CW'(STARVE_LIMIT))   wait_d[i] = wait_q[i] + 1'b1;
         else                                       wait_d[i] = wait_q[i];
      end
      outstanding_d = outstanding_q + OW'(accept) - OW'(v_q[READ_LATENCY-1]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q      <= '0;
         outstanding_q <= '0;
         v_q           <= '0;
         idx_q         <= '0;
         for (int i = 0; i < P; i++) wait_q[i] <= '0;
      end else begin
         rr_ptr_q      <= rr_ptr_d;
         outstanding_q <= outstanding_d;
         v_q[0]        <= accept;
         idx_q[0]      <= win_idx;
         for (int s = 1; s < READ_LATENCY; s++) begin
            v_q[s]   <= v_q[s-1];
            idx_q[s] <= idx_q[s-1];
         end
         for (int i = 0; i < P; i++) wait_q[i] <= wait_d[i];
      end
   end

   always_comb begin
      rsp_valid = '0;
      if (v_q[READ_LATENCY-1]) rsp_valid[idx_q[READ_LATENCY-1]] = 1'b1;
   end

   assign rsp_data    = mem_data;
   assign outstanding = outstanding_q;

endmodule

// File: tb/tb_memory_read_arbiter_tagged.sv
// Bench: dut0 is round-robin with latency 1, dut1 is priority mode with latency 3 and
// starvation limit 3. Each has a fixed-latency memory model and a response scoreboard.
module tb_memory_read_arbiter_tagged;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      int          port;
      logic [19:0] data;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   function automatic logic [19:0] memf(input logic [10:0] a);
      return {a[8:0], a} ^ 20'h5A5A5;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- dut0: ARB_MODE=0, READ_LATENCY=1 ----------------
   logic [4:0]  req_valid0, req_ready0, rsp_valid0;
   logic [10:0] a0 [5];
   logic [54:0] req_addr0;
   logic [19:0] rsp_data0, mem_data0;
   logic        mem_valid0, mem_ready0;
   logic [10:0] mem_addr0;
   logic [0:0]  outstanding0;
   logic [19:0] mp0;

   assign req_addr0 = {a0[4], a0[3], a0[2], a0[1], a0[0]};

   memory_read_arbiter_tagged #(
      .N(5), .MEMORY_ADDR_WIDTH(11), .MEMORY_WIDTH(20),
      .READ_LATENCY(1), .ARB_MODE(0), .STARVE_LIMIT(15)
   ) dut0 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid0), .req_addr(req_addr0), .req_ready(req_ready0),
      .rsp_valid(rsp_valid0), .rsp_data(rsp_data0),
      .mem_valid(mem_valid0), .mem_addr(mem_addr0), .mem_ready(mem_ready0),
      .mem_data(mem_data0), .outstanding(outstanding0)
   );

   always @(posedge clk or posedge rst) begin
      if (rst) mp0 <= '0;
      else     mp0 <= (mem_valid0 && mem_ready0) ? memf(mem_addr0) : 20'h0;
   end
   assign mem_data0 = mp0;

   // ---------------- dut1: ARB_MODE=1, READ_LATENCY=3, STARVE_LIMIT=3 ----------------
   logic [4:0]  req_valid1, req_ready1, rsp_valid1;
   logic [10:0] a1 [5];
   logic [54:0] req_addr1;
   logic [19:0] rsp_data1, mem_data1;
   logic        mem_valid1, mem_ready1;
   logic [10:0] mem_addr1;
   logic [1:0]  outstanding1;
   logic [19:0] mp1 [3];

   assign req_addr1 = {a1[4], a1[3], a1[2], a1[1], a1[0]};

   memory_read_arbiter_tagged #(
      .N(5), .MEMORY_ADDR_WIDTH(11), .MEMORY_WIDTH(20),
      .READ_LATENCY(3), .ARB_MODE(1), .STARVE_LIMIT(3)
   ) dut1 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid1), .req_addr(req_addr1), .req_ready(req_ready1),
      .rsp_valid(rsp_valid1), .rsp_data(rsp_data1),
      .mem_valid(mem_valid1), .mem_addr(mem_addr1), .mem_ready(mem_ready1),
      .mem_data(mem_data1), .outstanding(outstanding1)
   );

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mp1[0] <= '0; mp1[1] <= '0; mp1[2] <= '0;
      end else begin
         mp1[0] <= (mem_valid1 && mem_ready1) ? memf(mem_addr1) : 20'h0;
         mp1[1] <= mp1[0];
         mp1[2] <= mp1[1];
      end
   end
   assign mem_data1 = mp1[2];

   // ---------------- response scoreboards ----------------
   always @(negedge clk) begin
      if (!rst && rsp_valid0 != 5'h0) begin
         if (q0.size() == 0) chk("rsp0_unexpected", 32'(rsp_valid0), 32'h0);
         else begin
            exp_t e;
            e = q0.pop_front();
            chk("rsp0_port",  32'(rsp_valid0), 32'(1) << e.port);
            chk("rsp0_data",  32'(rsp_data0),  32'(e.data));
            chk("rsp0_cycle", 32'(cyc),        32'(e.cyc));
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && rsp_valid1 != 5'h0) begin
         if (q1.size() == 0) chk("rsp1_unexpected", 32'(rsp_valid1), 32'h0);
         else begin
            exp_t e;
            e = q1.pop_front();
            chk("rsp1_port",  32'(rsp_valid1), 32'(1) << e.port);
            chk("rsp1_data",  32'(rsp_data1),  32'(e.data));
            chk("rsp1_cycle", 32'(cyc),        32'(e.cyc));
         end
      end
   end

   // Called at the negedge of an expected accept cycle.
   task automatic expect_acc0(input int port);
      exp_t e;
      chk("req_ready0", 32'(req_ready0), 32'(1) << port);
      chk("mem_addr0",  32'(mem_addr0),  32'(a0[port]));
      e.cyc = cyc + 1; e.port = port; e.data = memf(a0[port]);
      q0.push_back(e);
   endtask

   task automatic expect_acc1(input int port);
      exp_t e;
      chk("req_ready1", 32'(req_ready1), 32'(1) << port);
      chk("mem_addr1",  32'(mem_addr1),  32'(a1[port]));
      e.cyc = cyc + 3; e.port = port; e.data = memf(a1[port]);
      q1.push_back(e);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   int out_exp [6] = '{0, 1, 2, 2, 1, 0};

   initial begin
      rst = 1'b1;
      req_valid0 = '0; mem_ready0 = 1'b0;
      req_valid1 = '0; mem_ready1 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         a0[i] = 11'h100 + 11'(i * 3);
         a1[i] = 11'h0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_rsp_valid0",   32'(rsp_valid0),   32'h0);
      chk("reset_outstanding0", 32'(outstanding0), 32'h0);
      chk("reset_mem_valid0",   32'(mem_valid0),   32'h0);
      chk("reset_rsp_valid1",   32'(rsp_valid1),   32'h0);
      chk("reset_outstanding1", 32'(outstanding1), 32'h0);
      next_cycle();
      rst = 1'b0;
      next_cycle();

      // Round-robin over all five ports
      req_valid0 = 5'h1F; mem_ready0 = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         expect_acc0(k % 5);
         if (k == 3) chk("rr_outstanding0", 32'(outstanding0), 32'h1);
         next_cycle();
      end

      // Memory stall: grant must hold on port 1 with nothing entering the pipe
      req_valid0 = 5'b01010; mem_ready0 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("stall_req_ready0", 32'(req_ready0), 32'h0);
         chk("stall_mem_valid0", 32'(mem_valid0), 32'h1);
         chk("stall_mem_addr0",  32'(mem_addr0),  32'(a0[1]));
         if (k == 3) chk("stall_outstanding0", 32'(outstanding0), 32'h0);
         next_cycle();
      end
      mem_ready0 = 1'b1;
      @(negedge clk); expect_acc0(1); next_cycle();
      req_valid0 = 5'b01000;
      @(negedge clk); expect_acc0(3); next_cycle();
      req_valid0 = 5'b00000;
      @(negedge clk);
      chk("idle_mem_valid0", 32'(mem_valid0), 32'h0);
      chk("idle_mem_addr0",  32'(mem_addr0),  32'h0);
      next_cycle();

      // Latency 3: port 2 then port 0 back to back, outstanding peaks at 2
      mem_ready1 = 1'b1;
      a1[2] = 11'h010; a1[0] = 11'h020;
      req_valid1 = 5'b00100;
      for (int s = 0; s < 6; s++) begin
         @(negedge clk);
         chk("lat3_outstanding1", 32'(outstanding1), 32'(out_exp[s]));
         if (s == 0) expect_acc1(2);
         if (s == 1) expect_acc1(0);
         next_cycle();
         if (s == 0) req_valid1 = 5'b00001;
         if (s == 1) req_valid1 = 5'b00000;
      end

      // Starvation guard: port 4 wins three times, then port 1 once
      a1[4] = 11'h7F0; a1[1] = 11'h0AB;
      req_valid1 = 5'b10010;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         expect_acc1((k % 4 == 3) ? 1 : 4);
         next_cycle();
      end
      req_valid1 = 5'b00000;
      repeat (4) next_cycle();

      // Reset one cycle after an accept drops the in-flight response and rr_ptr
      a1[2] = 11'h155;
      req_valid1 = 5'b00100;
      @(negedge clk);
      chk("rst_pre_req_ready1", 32'(req_ready1), 32'h4);
      next_cycle();
      req_valid1 = 5'b00000;
      rst = 1'b1;
      @(negedge clk);
      chk("rst_outstanding1", 32'(outstanding1), 32'h0);
      chk("rst_rsp_valid1",   32'(rsp_valid1),   32'h0);
      next_cycle();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("post_rst_rsp_valid1",   32'(rsp_valid1),   32'h0);
         chk("post_rst_outstanding1", 32'(outstanding1), 32'h0);
         next_cycle();
      end
      a1[0] = 11'h033; a1[3] = 11'h044;
      req_valid1 = 5'b01001;
      @(negedge clk); expect_acc1(0); next_cycle();
      req_valid1 = 5'b00000;
      repeat (5) next_cycle();

      chk("q0_drained", 32'(q0.size()), 32'h0);
      chk("q1_drained", 32'(q1.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
